// File: rtl/alu_rs_station_pkg.sv
// Shared types and constants for the ALU reservation station and its users.
package alu_rs_station_pkg;

    localparam int WORD_W    = 32;
    localparam int ROB_IDX_W = 4;
    localparam int RS_SIZE   = 16;
    localparam int RS_IDX_W  = $clog2(RS_SIZE);

    typedef logic [WORD_W-1:0]    WORD_TP;
    typedef logic [ROB_IDX_W-1:0] ROB_IDX_TP;
    typedef logic [RS_IDX_W-1:0]  RS_IDX_TP;
    typedef logic [4:0]           INST_OPT_TP;

    localparam INST_OPT_TP OPT_NOP  = 5'd0;
    localparam INST_OPT_TP OPT_ADD  = 5'd1;
    localparam INST_OPT_TP OPT_SUB  = 5'd2;
    localparam INST_OPT_TP OPT_AND  = 5'd3;
    localparam INST_OPT_TP OPT_OR   = 5'd4;
    localparam INST_OPT_TP OPT_XOR  = 5'd5;
    localparam INST_OPT_TP OPT_SLL  = 5'd6;
    localparam INST_OPT_TP OPT_SRL  = 5'd7;
    localparam INST_OPT_TP OPT_SRA  = 5'd8;
    localparam INST_OPT_TP OPT_SLT  = 5'd9;
    localparam INST_OPT_TP OPT_SLTU = 5'd10;
    localparam INST_OPT_TP OPT_BEQ  = 5'd11;
    localparam INST_OPT_TP OPT_BNE  = 5'd12;
    localparam INST_OPT_TP OPT_BLT  = 5'd13;
    localparam INST_OPT_TP OPT_BGE  = 5'd14;
    localparam INST_OPT_TP OPT_BLTU = 5'd15;
    localparam INST_OPT_TP OPT_BGEU = 5'd16;

    localparam logic   TRUE      = 1'b1;
    localparam logic   FALSE     = 1'b0;
    localparam WORD_TP ZERO_WORD = 32'd0;

endpackage

// File: rtl/alu_rs_station_lowbit_sel.sv
// Lowest-set-bit priority encoder: reports whether any bit is set and the
// index of the lowest one.
module rs_lowbit_sel #(
    parameter int N = 16
) (
    input  logic [N-1:0]         vec,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IDX_W = $clog2(N);

    // scan from the top so the lowest set bit is the last one written
    always_comb begin
        found = |vec;
        idx   = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/alu_rs_station.sv
// Reservation station for integer/branch ops: buffers dispatched entries,
// snoops both CDBs for operand wakeup and issues one ready entry per cycle.
module alu_rs_station
    import alu_rs_station_pkg::*;
#(
    parameter int RS_SIZE   = 16,
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 stall,
    input  logic                 disp_valid,
    input  INST_OPT_TP           disp_opt,
    input  logic [ROB_IDX_W-1:0] disp_q1,
    input  logic [ROB_IDX_W-1:0] disp_q2,
    input  logic [31:0]          disp_v1,
    input  logic [31:0]          disp_v2,
    input  logic [31:0]          disp_imm,
    input  logic [ROB_IDX_W-1:0] disp_rob_idx,
    output logic                 rs_full,
    input  logic                 cdb_alu_valid,
    input  logic [ROB_IDX_W-1:0] cdb_alu_src,
    input  logic [31:0]          cdb_alu_val,
    input  logic                 cdb_lsu_valid,
    input  logic [ROB_IDX_W-1:0] cdb_lsu_src,
    input  logic [31:0]          cdb_lsu_val,
    output logic                 rs_valid,
    output INST_OPT_TP           rs_opt,
    output logic [31:0]          rs_val1,
    output logic [31:0]          rs_val2,
    output logic [31:0]          rs_imm,
    output logic [ROB_IDX_W-1:0] rs_rob_idx
);

    localparam int                   IDX_W  = $clog2(RS_SIZE);
    localparam logic [ROB_IDX_W-1:0] NO_TAG = {ROB_IDX_W{1'b0}};

    logic [RS_SIZE-1:0]   busy_r;
    INST_OPT_TP           opt_r  [RS_SIZE];
    logic [ROB_IDX_W-1:0] q1_r   [RS_SIZE];
    logic [ROB_IDX_W-1:0] q2_r   [RS_SIZE];
    logic [ROB_IDX_W-1:0] rob_r  [RS_SIZE];
    WORD_TP               v1_r   [RS_SIZE];
    WORD_TP               v2_r   [RS_SIZE];
    WORD_TP               imm_r  [RS_SIZE];

    logic [ROB_IDX_W-1:0] wq1_s  [RS_SIZE];
    logic [ROB_IDX_W-1:0] wq2_s  [RS_SIZE];
    WORD_TP               wv1_s  [RS_SIZE];
    WORD_TP               wv2_s  [RS_SIZE];
    logic [ROB_IDX_W-1:0] dq1_s, dq2_s;
    WORD_TP               dv1_s, dv2_s;

    logic [RS_SIZE-1:0] ready_s;
    logic [RS_SIZE-1:0] free_s;
    logic [RS_SIZE-1:0] busy_nxt_s;
    logic               ready_found_s, free_found_s;
    logic [IDX_W-1:0]   ready_idx_s, free_idx_s;
    logic               issue_s, disp_accept_s;

    // A pending tag matching a valid CDB takes the broadcast value; ALU bus wins.
    function automatic void snoop(
        input  logic [ROB_IDX_W-1:0] q,
        input  WORD_TP               v,
        output logic [ROB_IDX_W-1:0] q_nxt,
        output WORD_TP               v_nxt
    );
        q_nxt = q;
        v_nxt = v;
        if (q != NO_TAG && cdb_alu_valid && cdb_alu_src == q) begin
            q_nxt = NO_TAG;
            v_nxt = cdb_alu_val;
        end else if (q != NO_TAG && cdb_lsu_valid && cdb_lsu_src == q) begin
            q_nxt = NO_TAG;
            v_nxt = cdb_lsu_val;
        end else begin
            q_nxt = q;
        end
    endfunction

    // operand wakeup for stored entries and forwarding for the incoming dispatch
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            snoop(q1_r[i], v1_r[i], wq1_s[i], wv1_s[i]);
            snoop(q2_r[i], v2_r[i], wq2_s[i], wv2_s[i]);
        end
        snoop(disp_q1, disp_v1, dq1_s, dv1_s);
        snoop(disp_q2, disp_v2, dq2_s, dv2_s);
    end

    // readiness is judged on start-of-cycle state only
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_s[i] = busy_r[i] && (q1_r[i] == NO_TAG) && (q2_r[i] == NO_TAG);
        end
    end

    assign free_s        = ~busy_r;
    assign rs_full       = ~rst & (&busy_r);
    assign disp_accept_s = disp_valid & ~rs_full;
    assign issue_s       = ~stall & ready_found_s;

    rs_lowbit_sel #(.N(RS_SIZE)) u_free_sel (
        .vec   (free_s),
        .found (free_found_s),
        .idx   (free_idx_s)
    );

    rs_lowbit_sel #(.N(RS_SIZE)) u_ready_sel (
        .vec   (ready_s),
        .found (ready_found_s),
        .idx   (ready_idx_s)
    );

    // issued slot is released while the dispatched slot is claimed; never the same index
    always_comb begin
        busy_nxt_s = busy_r;
        if (issue_s) begin
            busy_nxt_s[ready_idx_s] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (disp_accept_s && free_found_s) begin
            busy_nxt_s[free_idx_s] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // entry storage, wakeup capture and the registered issue bundle
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r     <= {RS_SIZE{1'b0}};
            rs_valid   <= FALSE;
            rs_opt     <= OPT_NOP;
            rs_val1    <= ZERO_WORD;
            rs_val2    <= ZERO_WORD;
            rs_imm     <= ZERO_WORD;
            rs_rob_idx <= NO_TAG;
        end else if (!rdy) begin
            rs_valid <= FALSE;
        end else if (flush) begin
            busy_r     <= {RS_SIZE{1'b0}};
            rs_valid   <= FALSE;
            rs_opt     <= OPT_NOP;
            rs_val1    <= ZERO_WORD;
            rs_val2    <= ZERO_WORD;
            rs_imm     <= ZERO_WORD;
            rs_rob_idx <= NO_TAG;
        end else begin
            busy_r <= busy_nxt_s;
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_r[i]) begin
                    q1_r[i] <= wq1_s[i];
                    v1_r[i] <= wv1_s[i];
                    q2_r[i] <= wq2_s[i];
                    v2_r[i] <= wv2_s[i];
                end
            end
            if (disp_accept_s && free_found_s) begin
                opt_r[free_idx_s] <= disp_opt;
                q1_r[free_idx_s]  <= dq1_s;
                v1_r[free_idx_s]  <= dv1_s;
                q2_r[free_idx_s]  <= dq2_s;
                v2_r[free_idx_s]  <= dv2_s;
                imm_r[free_idx_s] <= disp_imm;
                rob_r[free_idx_s] <= disp_rob_idx;
            end
            if (issue_s) begin
                rs_valid   <= TRUE;
                rs_opt     <= opt_r[ready_idx_s];
                rs_val1    <= v1_r[ready_idx_s];
                rs_val2    <= v2_r[ready_idx_s];
                rs_imm     <= imm_r[ready_idx_s];
                rs_rob_idx <= rob_r[ready_idx_s];
            end else begin
                rs_valid   <= FALSE;
                rs_opt     <= OPT_NOP;
                rs_val1    <= ZERO_WORD;
                rs_val2    <= ZERO_WORD;
                rs_imm     <= ZERO_WORD;
                rs_rob_idx <= NO_TAG;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_station.sv
// Directed-vector bench for alu_rs_station: dispatch/issue latency, CDB wakeup,
// forwarding, full handling, flush, rdy freeze and stall.
module tb_alu_rs_station;
    import alu_rs_station_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, stall;
    logic        disp_valid;
    INST_OPT_TP  disp_opt;
    logic [3:0]  disp_q1, disp_q2, disp_rob_idx;
    logic [31:0] disp_v1, disp_v2, disp_imm;
    logic        rs_full;
    logic        cdb_alu_valid, cdb_lsu_valid;
    logic [3:0]  cdb_alu_src, cdb_lsu_src;
    logic [31:0] cdb_alu_val, cdb_lsu_val;
    logic        rs_valid;
    INST_OPT_TP  rs_opt;
    logic [31:0] rs_val1, rs_val2, rs_imm;
    logic [3:0]  rs_rob_idx;

    int n_cmp = 0;
    int n_err = 0;

    alu_rs_station #(.RS_SIZE(16), .ROB_IDX_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .stall(stall),
        .disp_valid(disp_valid), .disp_opt(disp_opt),
        .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_v1(disp_v1), .disp_v2(disp_v2),
        .disp_imm(disp_imm), .disp_rob_idx(disp_rob_idx), .rs_full(rs_full),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_src(cdb_alu_src), .cdb_alu_val(cdb_alu_val),
        .cdb_lsu_valid(cdb_lsu_valid), .cdb_lsu_src(cdb_lsu_src), .cdb_lsu_val(cdb_lsu_val),
        .rs_valid(rs_valid), .rs_opt(rs_opt), .rs_val1(rs_val1), .rs_val2(rs_val2),
        .rs_imm(rs_imm), .rs_rob_idx(rs_rob_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_valid    = 1'b0;
        cdb_alu_valid = 1'b0;
        cdb_lsu_valid = 1'b0;
    endtask

    task automatic set_disp(input INST_OPT_TP opt, input logic [3:0] q1, input logic [31:0] v1,
                            input logic [3:0] q2, input logic [31:0] v2,
                            input logic [31:0] imm, input logic [3:0] rob);
        disp_valid   = 1'b1;
        disp_opt     = opt;
        disp_q1      = q1;
        disp_v1      = v1;
        disp_q2      = q2;
        disp_v2      = v2;
        disp_imm     = imm;
        disp_rob_idx = rob;
    endtask

    task automatic set_cdb_alu(input logic [3:0] src, input logic [31:0] val);
        cdb_alu_valid = 1'b1;
        cdb_alu_src   = src;
        cdb_alu_val   = val;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (rs_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", rs_valid); end
        n_cmp++; if (rs_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %0b want 0", rs_full); end
        n_cmp++; if (rs_opt !== OPT_NOP) begin n_err++; $display("FAIL reset_opt: got %0d want 0", rs_opt); end
        n_cmp++; if (rs_val1 !== 32'd0 || rs_val2 !== 32'd0 || rs_imm !== 32'd0) begin
            n_err++; $display("FAIL reset_data: got %h %h %h want 0", rs_val1, rs_val2, rs_imm); end
        n_cmp++; if (rs_rob_idx !== 4'd0) begin n_err++; $display("FAIL reset_rob: got %0d want 0", rs_rob_idx); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        set_disp(OPT_ADD, 4'd0, 32'd5, 4'd0, 32'd7, 32'h11, 4'd3);
        tick();
        idle_inputs();
        n_cmp++; if (rs_valid !== 1'b0) begin n_err++; $display("FAIL add_early: got %0b want 0", rs_valid); end
        tick();
        n_cmp++; if (rs_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %0b want 1", rs_valid); end
        n_cmp++; if (rs_opt !== OPT_ADD) begin n_err++; $display("FAIL add_opt: got %0d want %0d", rs_opt, OPT_ADD); end
        n_cmp++; if (rs_val1 !== 32'd5) begin n_err++; $display("FAIL add_val1: got %0d want 5", rs_val1); end
        n_cmp++; if (rs_val2 !== 32'd7) begin n_err++; $display("FAIL add_val2: got %0d want 7", rs_val2); end
        n_cmp++; if (rs_imm !== 32'h11) begin n_err++; $display("FAIL add_imm: got %h want 11", rs_imm); end
        n_cmp++; if (rs_rob_idx !== 4'd3) begin n_err++; $display("FAIL add_rob: got %0d want 3", rs_rob_idx); end
        tick();
        n_cmp++; if (rs_valid !== 1'b0) begin n_err++; $display("FAIL add_pulse: got %0b want 0", rs_valid); end
        n_cmp++; if (rs_val1 !== 32'd0) begin n_err++; $display("FAIL add_zero: got %0d want 0", rs_val1); end
    endtask

    task automatic test_wakeup();
        set_disp(OPT_SUB, 4'd4, 32'd0, 4'd0, 32'd1, 32'd0, 4'd5);
        tick();
        idle_inputs();
        n_cmp++; if (rs_valid !== 1'b0) begin n_err++; $display("FAIL wake_pre1: got %0b want 0", rs_valid); end
        tick();
        cdb_lsu_valid = 1'b1;
        cdb_lsu_src   = 4'd4;
        cdb_lsu_val   = 32'h10;
        n_cmp++; if (rs_valid !== 1'b0) begin n_err++; $display("FAIL wake_pre2: got %0b want 0", rs_valid); end
        tick();
        idle_inputs();
        n_cmp++; if (rs_valid !== 1'b0) begin n_err++; $display("FAIL wake_pre3: got %0b want 0", rs_valid); end
        tick();
        n_cmp++; if (rs_valid !== 1'b1) begin n_err++; $display("FAIL wake_valid: got %0b want 1", rs_valid); end
        n_cmp++; if (rs_val1 !== 32'h10) begin n_err++; $display("FAIL wake_val1: got %h want 10", rs_val1); end
        n_cmp++; if (rs_val2 !== 32'd1) begin n_err++; $display("FAIL wake_val2: got %h want 1", rs_val2); end
        n_cmp++; if (rs_opt !== OPT_SUB || rs_rob_idx !== 4'd5) begin
            n_err++; $display("FAIL wake_opt_rob: got %0d/%0d want %0d/5", rs_opt, rs_rob_idx, OPT_SUB); end
        tick();
    endtask

    task automatic test_forward();
        // both buses carry tag 6; the ALU value must be taken
        set_disp(OPT_AND, 4'd0, 32'd2, 4'd6, 32'd0, 32'd0, 4'd8);
        set_cdb_alu(4'd6, 32'd9);
        cdb_lsu_valid = 1'b1;
        cdb_lsu_src   = 4'd6;
        cdb_lsu_val   = 32'h55;
        tick();
        idle_inputs();
        n_cmp++; if (rs_valid !== 1'b0) begin n_err++; $display("FAIL fwd_early: got %0b want 0", rs_valid); end
        tick();
        n_cmp++; if (rs_valid !== 1'b1) begin n_err++; $display("FAIL fwd_valid: got %0b want 1", rs_valid); end
        n_cmp++; if (rs_val2 !== 32'd9) begin n_err++; $display("FAIL fwd_val2: got %h want 9", rs_val2); end
        n_cmp++; if (rs_val1 !== 32'd2 || rs_rob_idx !== 4'd8) begin
            n_err++; $display("FAIL fwd_val1_rob: got %h/%0d want 2/8", rs_val1, rs_rob_idx); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (rs_full !== 1'b0) begin n_err++; $display("FAIL fill_notfull%0d: got %0b want 0", i, rs_full); end
            set_disp(OPT_ADD, 4'd7, 32'd0, 4'd0, 32'(i), 32'(i), 4'(i));
            tick();
        end
        idle_inputs();
        n_cmp++; if (rs_full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %0b want 1", rs_full); end
        set_disp(OPT_OR, 4'd0, 32'd0, 4'd0, 32'd0, 32'd99, 4'd15);
        tick();
        idle_inputs();
        n_cmp++; if (rs_full !== 1'b1 || rs_valid !== 1'b0) begin
            n_err++; $display("FAIL drop_state: got full=%0b valid=%0b want 1/0", rs_full, rs_valid); end
        set_cdb_alu(4'd7, 32'h70);
        tick();
        idle_inputs();
        n_cmp++; if (rs_full !== 1'b1 || rs_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_pre: got full=%0b valid=%0b want 1/0", rs_full, rs_valid); end
        tick();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (rs_valid !== 1'b1 || rs_imm !== 32'(i)) begin
                n_err++; $display("FAIL b2b_issue%0d: got valid=%0b imm=%0d want 1/%0d", i, rs_valid, rs_imm, i); end
            n_cmp++; if (rs_val1 !== 32'h70 || rs_val2 !== 32'(i)) begin
                n_err++; $display("FAIL b2b_vals%0d: got %h/%h want 70/%0d", i, rs_val1, rs_val2, i); end
            if (i == 0) begin
                n_cmp++; if (rs_full !== 1'b0) begin n_err++; $display("FAIL b2b_full_drop: got %0b want 0", rs_full); end
            end
            tick();
        end
        n_cmp++; if (rs_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %0b want 0", rs_valid); end
    endtask

    task automatic test_flush();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_disp(OPT_XOR, 4'd0, 32'(i + 1), 4'd0, 32'd0, 32'd0, 4'(i + 1));
            tick();
        end
        stall = 1'b0;
        flush = 1'b1;
        set_disp(OPT_ADD, 4'd0, 32'h77, 4'd0, 32'd0, 32'd0, 4'd4);
        tick();
        idle_inputs();
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (rs_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid%0d: got %0b want 0", k, rs_valid); end
            if (k == 0) begin
                n_cmp++; if (rs_full !== 1'b0) begin n_err++; $display("FAIL flush_full: got %0b want 0", rs_full); end
            end
            tick();
        end
    endtask

    task automatic test_rdy_stall();
        set_disp(OPT_SLT, 4'd11, 32'd0, 4'd0, 32'd3, 32'd0, 4'd12);
        tick();
        idle_inputs();
        rdy = 1'b0;
        set_disp(OPT_ADD, 4'd0, 32'h21, 4'd0, 32'd0, 32'd0, 4'd13);
        tick();
        idle_inputs();
        n_cmp++; if (rs_valid !== 1'b0) begin n_err++; $display("FAIL rdy_frz1: got %0b want 0", rs_valid); end
        set_cdb_alu(4'd11, 32'h44);
        tick();
        idle_inputs();
        n_cmp++; if (rs_valid !== 1'b0) begin n_err++; $display("FAIL rdy_frz2: got %0b want 0", rs_valid); end
        tick();
        rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (rs_valid !== 1'b0) begin n_err++; $display("FAIL rdy_lost%0d: got %0b want 0", k, rs_valid); end
        end
        set_cdb_alu(4'd11, 32'h45);
        tick();
        idle_inputs();
        tick();
        n_cmp++; if (rs_valid !== 1'b1 || rs_rob_idx !== 4'd12) begin
            n_err++; $display("FAIL rdy_issue: got valid=%0b rob=%0d want 1/12", rs_valid, rs_rob_idx); end
        n_cmp++; if (rs_val1 !== 32'h45 || rs_val2 !== 32'd3) begin
            n_err++; $display("FAIL rdy_vals: got %h/%h want 45/3", rs_val1, rs_val2); end
        tick();

        stall = 1'b1;
        set_disp(OPT_SLL, 4'd14, 32'd0, 4'd0, 32'd2, 32'd0, 4'd14);
        tick();
        idle_inputs();
        set_cdb_alu(4'd14, 32'h66);
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (rs_valid !== 1'b0) begin n_err++; $display("FAIL stall_hold%0d: got %0b want 0", k, rs_valid); end
            tick();
        end
        stall = 1'b0;
        tick();
        n_cmp++; if (rs_valid !== 1'b1 || rs_rob_idx !== 4'd14) begin
            n_err++; $display("FAIL stall_issue: got valid=%0b rob=%0d want 1/14", rs_valid, rs_rob_idx); end
        n_cmp++; if (rs_val1 !== 32'h66 || rs_val2 !== 32'd2) begin
            n_err++; $display("FAIL stall_vals: got %h/%h want 66/2", rs_val1, rs_val2); end
        tick();
        n_cmp++; if (rs_valid !== 1'b0) begin n_err++; $display("FAIL stall_pulse: got %0b want 0", rs_valid); end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; stall = 1'b0;
        disp_valid = 1'b0; disp_opt = OPT_NOP;
        disp_q1 = 4'd0; disp_q2 = 4'd0; disp_v1 = 32'd0; disp_v2 = 32'd0;
        disp_imm = 32'd0; disp_rob_idx = 4'd0;
        cdb_alu_valid = 1'b0; cdb_alu_src = 4'd0; cdb_alu_val = 32'd0;
        cdb_lsu_valid = 1'b0; cdb_lsu_src = 4'd0; cdb_lsu_val = 32'd0;
        test_reset();
        test_add();
        test_wakeup();
        test_forward();
        test_back_to_back();
        test_flush();
        test_rdy_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
